// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg
// Shared constants and types for the run-time loadable instruction store.
// WORD_W / INSTR_W are the instruction width seen by the FPU decoder.
// A word is streamed as BYTES_PER_WORD bytes, LSB first. The last byte
// carries TOP_BITS payload bits. Its remaining upper bits are padding.
package instr_loader_pkg;

  localparam int WORD_W         = 50;
  localparam int INSTR_W        = WORD_W;
  localparam int DEPTH          = 16;
  localparam int ADDR_W         = 4;
  localparam int BYTES_PER_WORD = (WORD_W + 7) / 8;
  localparam int ASM_W          = 8 * BYTES_PER_WORD;
  // The first BYTES_PER_WORD-1 bytes are held in a register.
  // The final byte is used straight from the stream.
  localparam int LOW_W          = 8 * (BYTES_PER_WORD - 1);
  localparam int TOP_BITS       = WORD_W - LOW_W;
  localparam int PAD_W          = ASM_W - WORD_W;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
  localparam int CNT_W          = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_word_assembler.sv
// instr_word_assembler
// Collects BYTES_PER_WORD stream bytes into one instruction word.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear_i       drops any partial word and returns to byte 0
//   byte_en_i     a byte is accepted this cycle
//   byte_i        the stream byte
//   word_valid_o  single-cycle pulse on the edge that completes a word
//   word_o        the completed word; valid while word_valid_o is high
//   pad_err_o     the completing byte has a padding bit set
module instr_word_assembler
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o,
  output logic              pad_err_o
);

  logic [BIDX_W-1:0] idx_q, idx_d;
  logic [LOW_W-1:0]  asm_q, asm_d;
  logic              last;

  assign last = (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_en_i) begin
      if (last) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + BIDX_W'(1);
        for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
          if (idx_q == BIDX_W'(k)) asm_d[8*k +: 8] = byte_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

  // The final byte bypasses the register so the word can be written on the
  // same edge that accepts that byte.
  assign word_valid_o = byte_en_i && last && !clear_i;
  assign word_o       = {byte_i[TOP_BITS-1:0], asm_q};
  assign pad_err_o    = word_valid_o && (|byte_i[7:TOP_BITS]);

endmodule

// File: rtl/instr_loader.sv
// instr_loader
// A 16 x 50-bit instruction store that is loaded from a byte stream at run time.
// It stands in for the file-initialised ROM used by the FPU sequencer.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      pulse that starts, or restarts, a load at address 0
//   in_valid   byte-stream valid
//   in_byte    stream byte, LSB of each word first
//   in_ready   high while loading
//   load_done  high after all DEPTH words are written, until start or rst
//   fmt_err    sticky flag for a nonzero padding bit in the current load
//   word_cnt   number of words written in the current load
//   PC_addr    read address
//   data       combinational read data, mem[PC_addr]
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              load_done,
  output logic              fmt_err,
  output logic [CNT_W-1:0]  word_cnt,
  input  logic [ADDR_W-1:0] PC_addr,
  output logic [WORD_W-1:0] data
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic                fmt_err_q, fmt_err_d;

  logic                accept;
  logic                word_valid;
  logic                pad_err;
  logic [WORD_W-1:0]   word;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  assign in_ready  = (state_q == LOAD);
  assign load_done = (state_q == DONE);
  assign fmt_err   = fmt_err_q;
  assign word_cnt  = word_cnt_q;

  // start and rst both take priority over the byte presented in the same
  // cycle. Masking the byte here also stops a late memory write.
  assign accept = in_valid && in_ready && !start && !rst;

  instr_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start),
    .byte_en_i    (accept),
    .byte_i       (in_byte),
    .word_valid_o (word_valid),
    .word_o       (word),
    .pad_err_o    (pad_err)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    word_cnt_d = word_cnt_q;
    fmt_err_d  = fmt_err_q;
    if (start) begin
      state_d    = LOAD;
      wr_ptr_d   = '0;
      word_cnt_d = '0;
      fmt_err_d  = 1'b0;
    end else if (word_valid) begin
      // After the last word the pointer wraps to 0 on its own.
      wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
      word_cnt_d = word_cnt_q + CNT_W'(1);
      if (pad_err) fmt_err_d = 1'b1;
      if (wr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      word_cnt_q <= '0;
      fmt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      word_cnt_q <= word_cnt_d;
      fmt_err_q  <= fmt_err_d;
    end
  end

  // Memory contents are not reset. Entries keep their values until they are
  // overwritten.
  always_ff @(posedge clk) begin
    if (word_valid) mem_q[wr_ptr_q] <= word;
  end

  assign data = mem_q[PC_addr];

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_byte;
  logic        in_ready, load_done, fmt_err;
  logic [4:0]  word_cnt;
  logic [3:0]  PC_addr;
  logic [49:0] data;

  int tests = 0;
  int fails = 0;

  // Reference model: the load is a list of bytes, with a word count used as the write address.
  bit          m_loading, m_done, m_fmt;
  int          m_cnt;
  logic [7:0]  m_bytes[$];
  logic [49:0] m_mem[16];
  bit          m_wr[16];

  always #5 clk = ~clk;

  instr_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .load_done (load_done),
    .fmt_err   (fmt_err),
    .word_cnt  (word_cnt),
    .PC_addr   (PC_addr),
    .data      (data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit v, input logic [7:0] b);
    logic [55:0] w;
    if (r) begin
      m_loading = 0; m_done = 0; m_fmt = 0; m_cnt = 0; m_bytes.delete();
    end else if (s) begin
      m_loading = 1; m_done = 0; m_fmt = 0; m_cnt = 0; m_bytes.delete();
    end else if (m_loading && v) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 7) begin
        w = '0;
        for (int k = 0; k < 7; k++) w = w | (56'(m_bytes[k]) << (8 * k));
        if (w[55:50] != 6'd0) m_fmt = 1;
        m_mem[m_cnt] = w[49:0];
        m_wr[m_cnt]  = 1;
        m_cnt++;
        m_bytes.delete();
        if (m_cnt == 16) begin
          m_loading = 0;
          m_done    = 1;
        end
      end
    end
  endtask

  // Drive one cycle, update the model at the edge, then check the outputs 1 time unit later.
  task automatic step(input bit r, input bit s, input bit v, input logic [7:0] b);
    rst = r; start = s; in_valid = v; in_byte = b;
    @(posedge clk);
    model_edge(r, s, v, b);
    #1;
    chk("in_ready", 64'(in_ready), 64'(m_loading));
    chk("load_done", 64'(load_done), 64'(m_done));
    chk("fmt_err", 64'(fmt_err), 64'(m_fmt));
    chk("word_cnt", 64'(word_cnt), 64'(m_cnt));
    if (m_wr[PC_addr]) chk("data", 64'(data), 64'(m_mem[PC_addr]));
  endtask

  task automatic send_word(input logic [55:0] w);
    for (int k = 0; k < 7; k++) begin
      PC_addr = 4'($urandom_range(0, 15));
      step(0, 0, 1, w[8*k +: 8]);
    end
  endtask

  task automatic rand_word();
    logic [55:0] w;
    w = {$urandom, $urandom};
    send_word(w);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      PC_addr = 4'(a);
      step(0, 0, 0, 8'h00);
    end
  endtask

  initial begin
    logic [55:0] w;
    int          guard;
    rst = 1; start = 0; in_valid = 0; in_byte = 0; PC_addr = 0;
    for (int i = 0; i < 16; i++) m_wr[i] = 0;

    // Reset, then bytes presented while idle must be ignored.
    step(1, 0, 0, 8'h00);
    step(1, 0, 1, 8'h5A);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom));
    chk("idle_cnt", 64'(word_cnt), 64'd0);

    // A byte presented together with start is dropped.
    step(0, 1, 1, 8'hAB);
    for (int i = 0; i < 16; i++) begin
      w = 56'(i);
      send_word(w);
    end
    chk("done_after_112", 64'(load_done), 64'd1);
    PC_addr = 4'd5; step(0, 0, 0, 8'h00);
    chk("data_pc5", 64'(data), 64'h5);
    PC_addr = 4'd15; step(0, 0, 0, 8'h00);
    chk("data_pc15", 64'(data), 64'hF);
    step(0, 0, 1, 8'h77);

    // Padding error on word 0, followed by random words with random padding.
    step(0, 1, 0, 8'h00);
    w = {8'h04, 48'($urandom) ^ (48'($urandom) << 16)};
    send_word(w);
    chk("fmt_set", 64'(fmt_err), 64'd1);
    PC_addr = 4'd0; step(0, 0, 0, 8'h00);
    chk("pad_word0", 64'(data), 64'({2'b00, w[47:0]}));
    for (int i = 1; i < 16; i++) rand_word();
    chk("fmt_persist", 64'(fmt_err), 64'd1);

    // Restart after 3 words and 4 bytes. The partial word must be discarded.
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) rand_word();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'($urandom));
    PC_addr = 4'd3;
    step(0, 1, 1, 8'hEE);
    chk("restart_cnt", 64'(word_cnt), 64'd0);
    chk("restart_fmt", 64'(fmt_err), 64'd0);
    for (int i = 0; i < 16; i++) send_word(56'h03_FFFF_FFFF_FFFF);
    read_all();
    PC_addr = 4'd9; step(0, 0, 0, 8'h00);
    chk("ones_pc9", 64'(data), 64'h3_FFFF_FFFF_FFFF);

    // Toggle in_valid every cycle with random bytes. Exactly 112 accepted bytes must be needed.
    step(0, 1, 0, 8'h00);
    guard = 0;
    while (!m_done && guard < 400) begin
      PC_addr = 4'($urandom_range(0, 15));
      step(0, 0, guard[0] == 1'b0, 8'($urandom));
      guard++;
    end
    chk("toggle_done", 64'(load_done), 64'd1);
    chk("toggle_cycles", 64'(guard), 64'd223);
    read_all();

    // Apply rst during byte 3 of word 9.
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 9; i++) rand_word();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'($urandom));
    step(1, 0, 1, 8'h3C);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_cnt", 64'(word_cnt), 64'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom));
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
